hazard_unit_param: RTL and testbench

//  Parametrised hazard unit for the 5-stage pipelined ARM core (F/D/E/M/W).

---
 rtl/hazard_unit_param.sv | 145 ++++++++++++++
 tb/tb_hazard_unit_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_param.sv
// Hazard unit for the 5-stage core: operand forwarding, load-use stall, branch/PC flushes,
// data-memory wait tracking with sticky timeout, and saturating stall/flush counters.
module hazard_unit_param #(
  parameter int REGW    = 4,
  parameter int NSRC    = 3,
  parameter int PC_IDX  = 15,
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NSRC*REGW-1:0] SrcD,
  input  logic [NSRC*REGW-1:0] SrcE,
  input  logic [REGW-1:0]      WA3E,
  input  logic [REGW-1:0]      WA3M,
  input  logic [REGW-1:0]      WA3W,
  input  logic                 RegWriteE,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemtoRegE,
  input  logic                 MemAccessM,
  input  logic                 DmemReady,
  input  logic                 PCWrPendingF,
  input  logic                 PCSrcW,
  input  logic                 BranchTakenE,
  input  logic                 CntClr,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic [2*NSRC-1:0]    ForwardE,
  output logic                 MemTimeout,
  output logic [CNTW-1:0]      StallCnt,
  output logic [CNTW-1:0]      FlushCnt
);

  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [REGW-1:0] PC_ADDR = REGW'(PC_IDX);
  localparam logic [WCW-1:0]  WAIT_MAX = WCW'(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_inc;
  logic           ldr_stall;
  logic           mem_stall;

  assign mem_stall = MemAccessM & ~DmemReady;
  assign wait_inc  = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;

  always_comb begin
    ldr_stall = 1'b0;
    ForwardE  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (SrcD[i*REGW +: REGW] == WA3E && SrcD[i*REGW +: REGW] != PC_ADDR)
        ldr_stall = 1'b1;
      // PC reads are served from PCPlus8, so R15 is never forwarded.
      if (reset_n && SrcE[i*REGW +: REGW] != PC_ADDR) begin
        if (RegWriteM && SrcE[i*REGW +: REGW] == WA3M)
          ForwardE[2*i +: 2] = 2'b10;
        else if (RegWriteW && SrcE[i*REGW +: REGW] == WA3W)
          ForwardE[2*i +: 2] = 2'b01;
      end
    end
    ldr_stall = ldr_stall & MemtoRegE & RegWriteE;
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (reset_n) begin
      if (mem_stall) begin
        // Whole pipe freezes; redirects stay parked in E until memory releases.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = ldr_stall | PCWrPendingF;
        StallD = ldr_stall;
        FlushE = ldr_stall | BranchTakenE;
        FlushD = PCWrPendingF | PCSrcW | BranchTakenE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (mem_stall) begin
            state    <= WAIT;
            wait_cnt <= wait_inc;
            if (wait_inc == WAIT_MAX) MemTimeout <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_stall) begin
            wait_cnt <= wait_inc;
            if (wait_inc == WAIT_MAX) MemTimeout <= 1'b1;
          end else begin
            state    <= IDLE;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (CntClr)
        StallCnt <= '0;
      else if (StallF && StallCnt != '1)
        StallCnt <= StallCnt + 1'b1;
      if (CntClr)
        FlushCnt <= '0;
      else if (FlushE && FlushCnt != '1)
        FlushCnt <= FlushCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_param.sv
// Directed scenarios plus randomized traffic, checked each cycle against a rule-level model.
module tb_hazard_unit_param;
  localparam int REGW = 4, NSRC = 3, TMO = 4, CW = 8;

  logic clk = 1'b0, reset_n;
  logic [NSRC*REGW-1:0] SrcD, SrcE;
  logic [REGW-1:0] WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemAccessM, DmemReady;
  logic PCWrPendingF, PCSrcW, BranchTakenE, CntClr;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [2*NSRC-1:0] ForwardE;
  logic [CW-1:0] StallCnt, FlushCnt;

  int total = 0, fails = 0;
  int run_len = 0, m_sc = 0, m_fc = 0;
  bit m_to = 0;

  hazard_unit_param #(.REGW(REGW), .NSRC(NSRC), .PC_IDX(15), .TIMEOUT(TMO), .CNTW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .SrcD(SrcD), .SrcE(SrcE),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemAccessM(MemAccessM), .DmemReady(DmemReady),
    .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .CntClr(CntClr), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .ForwardE(ForwardE),
    .MemTimeout(MemTimeout), .StallCnt(StallCnt), .FlushCnt(FlushCnt));

  always #5 clk = ~clk;

  function automatic logic [11:0] src3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return {c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    SrcD = '0; SrcE = '0; WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    MemAccessM = 0; DmemReady = 1; PCWrPendingF = 0; PCSrcW = 0;
    BranchTakenE = 0; CntClr = 0;
  endtask

  // One clock: inputs already applied after the falling edge; check, then advance the model.
  task automatic cycle();
    logic [6:0] e_ctl;
    logic [5:0] e_fwd;
    logic       ldr, ms, e_sf, e_fe;
    logic [3:0] s;
    #1;
    if (!reset_n) begin
      run_len = 0; m_to = 0; m_sc = 0; m_fc = 0;
    end
    e_fwd = '0;
    ldr = 0;
    for (int i = 0; i < NSRC; i++) begin
      s = SrcE[i*4 +: 4];
      if (s != 15 && RegWriteM && s == WA3M) e_fwd[2*i +: 2] = 2'b10;
      else if (s != 15 && RegWriteW && s == WA3W) e_fwd[2*i +: 2] = 2'b01;
      s = SrcD[i*4 +: 4];
      if (s == WA3E && s != 15 && MemtoRegE && RegWriteE) ldr = 1;
    end
    ms = MemAccessM && !DmemReady;
    if (!reset_n) begin
      e_ctl = '0; e_fwd = '0; e_sf = 0; e_fe = 0;
    end else if (ms) begin
      e_ctl = 7'b1111_001; e_sf = 1; e_fe = 0;
    end else begin
      e_sf = ldr | PCWrPendingF;
      e_fe = ldr | BranchTakenE;
      e_ctl = {e_sf, ldr, 1'b0, 1'b0, PCWrPendingF | PCSrcW | BranchTakenE, e_fe, 1'b0};
    end
    chk("ctl{SF,SD,SE,SM,FD,FE,FW}", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, e_ctl);
    chk("ForwardE", ForwardE, e_fwd);
    chk("MemTimeout", MemTimeout, m_to);
    chk("StallCnt", StallCnt, m_sc);
    chk("FlushCnt", FlushCnt, m_fc);
    @(posedge clk);
    if (reset_n) begin
      if (ms) begin
        run_len = (run_len < TMO) ? run_len + 1 : TMO;
        if (run_len == TMO) m_to = 1;
      end else run_len = 0;
      if (CntClr) m_sc = 0; else if (e_sf) m_sc = (m_sc < 255) ? m_sc + 1 : 255;
      if (CntClr) m_fc = 0; else if (e_fe) m_fc = (m_fc < 255) ? m_fc + 1 : 255;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] r[6];
    idle_inputs();
    reset_n = 0;
    cycle(); cycle();
    reset_n = 1;
    cycle();

    // 1: forwarding from M, then from W only
    SrcE = src3(1, 5, 6); WA3M = 1; RegWriteM = 1;
    cycle();
    chk("t1_fwdM", ForwardE[1:0], 2'b10);
    RegWriteM = 0; WA3M = 0; WA3W = 1; RegWriteW = 1;
    cycle();
    chk("t1_fwdW", ForwardE[1:0], 2'b01);
    SrcE = src3(1, 5, 6); WA3M = 1; RegWriteM = 1;
    cycle();
    chk("t1_MbeatsW", ForwardE[1:0], 2'b10);
    idle_inputs();

    // 2: load-use stall, then forward from W
    SrcD = src3(2, 4, 7); WA3E = 2; MemtoRegE = 1; RegWriteE = 1;
    cycle();
    chk("t2_stall", {StallF, StallD, FlushE}, 3'b111);
    MemtoRegE = 0; RegWriteE = 0; WA3E = 0; WA3M = 2; RegWriteM = 1; MemAccessM = 1;
    cycle();
    chk("t2_release", StallD, 1'b0);
    idle_inputs();
    SrcE = src3(2, 4, 7); WA3W = 2; RegWriteW = 1;
    cycle();
    chk("t2_fwdW", ForwardE[1:0], 2'b01);
    idle_inputs();

    // 3: three memory wait cycles
    MemAccessM = 1; DmemReady = 0;
    repeat (3) cycle();
    DmemReady = 1;
    cycle();
    chk("t3_ready_not_stalled", StallF, 1'b0);
    idle_inputs();
    cycle();
    chk("t3_timeout_low", MemTimeout, 1'b0);

    // 4: timeout after the 4th wait cycle, sticky until reset
    MemAccessM = 1; DmemReady = 0;
    repeat (6) cycle();
    DmemReady = 1;
    cycle();
    idle_inputs();
    cycle();
    chk("t4_sticky", MemTimeout, 1'b1);
    reset_n = 0;
    cycle();
    reset_n = 1;
    cycle();

    // 5: branch parked during memory stall
    MemAccessM = 1; DmemReady = 0; BranchTakenE = 1;
    repeat (2) cycle();
    DmemReady = 1;
    cycle();
    chk("t5_flush_on_release", {FlushD, FlushE}, 2'b11);
    idle_inputs();

    // 6: PC never forwarded; clear wins over increment
    SrcE = src3(15, 3, 3); WA3M = 15; RegWriteM = 1;
    cycle();
    chk("t6_pc_nofwd", ForwardE[1:0], 2'b00);
    idle_inputs();
    PCWrPendingF = 1; CntClr = 1;
    cycle();
    CntClr = 0; PCWrPendingF = 0;
    cycle();
    chk("t6_cntclr", StallCnt, 0);

    // reset in the middle of a wait
    MemAccessM = 1; DmemReady = 0;
    repeat (2) cycle();
    reset_n = 0;
    cycle();
    idle_inputs();
    reset_n = 1;
    cycle();

    // counter saturation
    PCWrPendingF = 1; BranchTakenE = 1;
    repeat (260) cycle();
    chk("sat_stall", StallCnt, 8'hFF);
    idle_inputs();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      foreach (r[k]) r[k] = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
      SrcD = src3(r[0], r[1], r[2]); SrcE = src3(r[3], r[4], r[5]);
      WA3E = 4'($urandom_range(0, 3));
      WA3M = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom); MemAccessM = 1'($urandom);
      DmemReady = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
      PCWrPendingF = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 5) == 0); CntClr = ($urandom_range(0, 40) == 0);
      reset_n = ($urandom_range(0, 150) != 0);
      cycle();
    end
    reset_n = 1;
    idle_inputs();
    cycle();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
